// File: rtl/inst_loader_if.sv
// Byte-stream handshake carrying a program image into inst_loader.
// The source drives DataIn/DataValid; the loader answers with DataReady.
interface inst_loader_if;
  logic [7:0] DataIn;
  logic       DataValid;
  logic       DataReady;

  modport master (output DataIn, output DataValid, input DataReady);
  modport slave  (input DataIn, input DataValid, output DataReady);
endinterface

// File: rtl/inst_loader.sv
// Instruction-memory loader: assembles a byte stream into 9-bit instructions
// and writes them into a 2**AW-deep RAM. The RAM is also read combinationally
// by the fetch stage. The core is stalled through Loading/Done until the
// whole program is resident.
// The stream header holds a 10-bit count N, so AW is expected to be 10.
// IW is fixed at 9 by the ISA.
// Optional feature: define INST_LOADER_CHECKSUM_EN to expect one trailer byte.
// That byte is compared against the XOR of all header and data bytes, and
// a mismatch raises Error.
module inst_loader #(
  parameter int AW = 10,
  parameter int IW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  inst_loader_if.slave  s,
  input  logic [AW-1:0] InstAddress,
  output logic [IW-1:0] InstOut,
  output logic          Loading,
  output logic          Done,
  output logic [AW:0]   LoadCount,
  output logic          Error
);

  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, DONE, CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, DONE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    n_q, n_d;
  logic [7:0]    lo_q, lo_d;
  logic          we;
  logic          accept;
  logic          last;
  logic [IW-1:0] mem_q [0:(2**AW)-1];

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_q, err_d;
`endif

  assign accept = s.DataValid && s.DataReady;
  // The final word is the one written while the pointer equals N.
  assign last   = ({1'b0, ptr_q} == CW'(n_q));

  // Next-state, pointer/count and RAM write-enable decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    lo_d    = lo_q;
    we      = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
    if (accept && (state_q != CHK)) csum_d = csum_q ^ s.DataIn;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = HDR_LO;
          ptr_d   = '0;
          cnt_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      HDR_LO: begin
        if (accept) begin
          n_d[7:0] = s.DataIn;
          state_d  = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          n_d[9:8] = s.DataIn[1:0];
          state_d  = DAT_LO;
        end
      end
      DAT_LO: begin
        if (accept) begin
          lo_d    = s.DataIn;
          state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          we    = 1'b1;
          ptr_d = ptr_q + PTR_ONE;
          cnt_d = cnt_q + CNT_ONE;
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = last ? CHK : DAT_LO;
`else
          state_d = last ? DONE : DAT_LO;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          err_d   = (s.DataIn != csum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Control state; Reset overrides Start and any simultaneous accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Header count and pending low byte; pure data, no reset needed.
  always_ff @(posedge Clk) begin
    n_q  <= n_d;
    lo_q <= lo_d;
  end

  // Instruction RAM write port; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (we && !Reset) mem_q[ptr_q] <= {s.DataIn[0], lo_q};
  end

  assign InstOut     = mem_q[InstAddress];
  assign s.DataReady = (state_q != IDLE) && (state_q != DONE);
  assign Loading     = (state_q != IDLE) && (state_q != DONE);
  assign Done        = (state_q == DONE);
  assign LoadCount   = cnt_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign Error       = err_q;
`else
  assign Error       = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: expected RAM words are queued as the
// program is streamed in and compared against the read port afterwards.
module tb_inst_loader;
  localparam int AW = 10;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr;
  logic [IW-1:0] inst;
  logic          loading;
  logic          done;
  logic [AW:0]   cnt;
  logic          err;

  inst_loader_if bus ();

  inst_loader #(.AW(AW), .IW(IW)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .s(bus),
    .InstAddress(addr), .InstOut(inst),
    .Loading(loading), .Done(done), .LoadCount(cnt), .Error(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  csum_tb;
  logic [8:0]  prog [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    csum_tb = 8'h00;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    logic [7:0] junk;
    if (gap) begin
      junk = 8'($urandom);
      bus.DataIn = junk;
      bus.DataValid = 1'b0;
      tick();
    end
    bus.DataIn = b;
    bus.DataValid = 1'b1;
    n = 0;
    while (!bus.DataReady && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    bus.DataValid = 1'b0;
    csum_tb = csum_tb ^ b;
  endtask

  task automatic send_word(input logic [8:0] w, input bit gap);
    logic [6:0] junk;
    junk = 7'($urandom);
    send_byte(w[7:0], gap);
    send_byte({junk, w[8]}, gap);
  endtask

  task automatic send_trailer();
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(csum_tb, 1'b0);
`endif
  endtask

  // Stream header plus prog[0..nw-1], queueing the expected RAM image.
  task automatic load_prog(input int nw, input bit gap);
    logic [9:0]  n;
    logic [5:0]  junk;
    exp_t        e;
    n = 10'(nw - 1);
    junk = 6'($urandom);
    send_byte(n[7:0], gap);
    send_byte({junk, n[9:8]}, gap);
    for (int i = 0; i < nw; i++) begin
      send_word(prog[i], gap);
      e.a = AW'(i);
      e.d = prog[i];
      sb.push_back(e);
    end
    send_trailer();
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] d);
    addr = a;
    #1;
    chk(tag, 32'(inst), 32'(d));
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      read_chk($sformatf("ram[%0d]", e.a), e.a, e.d);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    addr = '0;
    bus.DataIn = 8'h00;
    bus.DataValid = 1'b0;
    csum_tb = 8'h00;
    tick();
    tick();
    chk("rst_ready", 32'(bus.DataReady), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Single instruction 0x12A.
    pulse_start();
    chk("t1_ready_after_start", 32'(bus.DataReady), 32'd1);
    chk("t1_loading", 32'(loading), 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h2A, 1'b0);
    send_byte(8'h01, 1'b0);
    send_trailer();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(cnt), 32'd1);
    chk("t1_loading_off", 32'(loading), 32'd0);
    chk("t1_ready_off", 32'(bus.DataReady), 32'd0);
    chk("t1_error", 32'(err), 32'd0);
    read_chk("t1_ram0", '0, 9'h12A);
    tick();

    // Three words with idle gaps between bytes.
    prog[0] = 9'h1FF; prog[1] = 9'h000; prog[2] = 9'h0A5;
    pulse_start();
    load_prog(3, 1'b1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(cnt), 32'd3);
    drain_sb();

    // Full 1024-word program, data = address[8:0].
    for (int i = 0; i < 1024; i++) prog[i] = 9'(i);
    pulse_start();
    load_prog(1024, 1'b0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_count", 32'(cnt), 32'd1024);
    chk("t3_error", 32'(err), 32'd0);
    drain_sb();
    read_chk("t3_ram1023", 10'd1023, 9'h1FF);
    read_chk("t3_ram0", 10'd0, 9'h000);

    // Reset after 2 of 5 words, with Start in the same cycle.
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(9'h155, 1'b0);
    send_word(9'h0AA, 1'b0);
    send_byte(8'h33, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    bus.DataValid = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    bus.DataValid = 1'b0;
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_count", 32'(cnt), 32'd0);
    chk("t4_loading", 32'(loading), 32'd0);
    chk("t4_ready", 32'(bus.DataReady), 32'd0);
    tick();
    chk("t4_start_ignored", 32'(loading), 32'd0);
    read_chk("t4_ram0", 10'd0, 9'h155);
    read_chk("t4_ram1", 10'd1, 9'h0AA);
    read_chk("t4_ram2", 10'd2, 9'h002);
    tick();

    // Start mid-load is ignored; Start in DONE reloads from address 0.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(9'h101, 1'b0);
    send_byte(8'h77, 1'b0);
    pulse_start();
    chk("t5_midstart_loading", 32'(loading), 32'd1);
    chk("t5_midstart_count", 32'(cnt), 32'd1);
    send_byte(8'h00, 1'b0);
    send_trailer();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_count", 32'(cnt), 32'd2);
    read_chk("t5_ram1", 10'd1, 9'h077);
    tick();
    pulse_start();
    chk("t5_restart_done", 32'(done), 32'd0);
    chk("t5_restart_count", 32'(cnt), 32'd0);
    chk("t5_restart_ready", 32'(bus.DataReady), 32'd1);
    prog[0] = 9'h055;
    load_prog(1, 1'b0);
    chk("t5_done2", 32'(done), 32'd1);
    chk("t5_count2", 32'(cnt), 32'd1);
    drain_sb();
    read_chk("t5_ram1_kept", 10'd1, 9'h077);
    tick();

`ifdef INST_LOADER_CHECKSUM_EN
    // Good and bad trailer bytes.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h2A, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("t6_wait_trailer", 32'(done), 32'd0);
    send_byte(8'h2B, 1'b0);
    chk("t6_good_error", 32'(err), 32'd0);
    chk("t6_good_done", 32'(done), 32'd1);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h2A, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t6_bad_error", 32'(err), 32'd1);
    chk("t6_bad_done", 32'(done), 32'd1);
    pulse_start();
    chk("t6_error_cleared", 32'(err), 32'd0);
`else
    chk("t6_error_tied", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write side of the 9-bit instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles the bytes into 9-bit instructions.
- It writes the instructions into an internal 2**AW x IW instruction RAM.
- It exposes the same combinational read port the fetch stage uses (InstAddress -> InstOut).
- The core is held off, via Loading/Done, until the program is resident.

Parameters:
- AW, 10, instruction address width; RAM depth is 2**AW.
- IW, 9, instruction width. Fixed at 9 by the ISA; the parameter exists only for documentation and assertions.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse; begins a load when in IDLE or DONE.
- DataIn  input  8  stream byte.
- DataValid  input  1  DataIn is valid this cycle.
- DataReady  output  1  loader accepts a byte this cycle.
- InstAddress  input  AW  fetch read address.
- InstOut  output  IW  combinational read data, inst_ram[InstAddress].
- Loading  output  1  load in progress; the core must stall.
- Done  output  1  program fully loaded; held high.
- LoadCount  output  AW+1  number of instructions written in the current or last load.
- Error  output  1  checksum mismatch (optional feature only).

Behaviour:
- Reset values: state=IDLE, DataReady=0, Loading=0, Done=0, LoadCount=0, Error=0, write pointer=0, checksum accumulator=0. RAM contents are NOT cleared by Reset.
- Handshake: a byte is accepted at a rising edge where DataValid & DataReady.
  - DataReady is a registered-state decode: 1 only in HDR_LO, HDR_HI, DAT_LO, DAT_HI (and CHK when the feature is enabled).
  - DataReady does not depend on DataValid.
- Stream format:
  - Byte 0 = N[7:0], byte 1 = {6'bx, N[9:8]}.
  - Number of instructions = N+1, range 1..1024.
  - Then, per instruction: low byte = inst[7:0], high byte = {7'bx, inst[8]}. Ignored bits are don't-care.
- State machine:
  - IDLE: Start -> HDR_LO.
  - HDR_LO: on accept, latch N[7:0] -> HDR_HI.
  - HDR_HI: on accept, latch N[9:8] -> DAT_LO.
  - DAT_LO: on accept, hold low byte -> DAT_HI.
  - DAT_HI: on accept, write inst_ram[ptr] <= {DataIn[0], lo}, ptr++, LoadCount++.
    - If ptr == N: -> DONE (or -> CHK when the feature is enabled).
    - Else -> DAT_LO.
  - DONE: Done=1. Start -> HDR_LO, clearing Done, LoadCount, ptr and Error that same edge.
- Entering HDR_LO from IDLE also clears LoadCount, ptr and the checksum accumulator.
- Loading = 1 in every state except IDLE and DONE.
- Start while Loading is ignored.
- No accept in a cycle leaves all state unchanged; no timeout.
- Write timing: the RAM write commits at the DAT_HI accept edge.
  - A same-cycle read of that address returns the old contents.
  - The new value is visible on the following cycle.
- Wrap-around: N=1023 writes addresses 0..1023. ptr must not wrap before DONE; LoadCount reaches 1024 (needs AW+1 bits).
- Reset mid-load: returns to IDLE next edge; outputs at reset values; words already written remain in RAM; the partial byte is discarded.
- Reset has priority over Start and over a simultaneous accept.
- The read port is independent of state and always reflects RAM contents.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- When defined:
  - After the last DAT_HI the FSM goes to CHK and accepts one trailer byte.
  - Expected value = XOR of every accepted header and data byte, full 8 bits including don't-care bits.
  - On the CHK accept: Error <= (trailer != expected), then -> DONE.
  - Error holds until Reset or the next Start.
- When undefined:
  - No CHK state; DAT_HI goes directly to DONE.
  - Error is tied to 0; no accumulator logic.

Test Plan:
- Reset then Start, stream 00 00 | 2A 01 -> DataReady high from the cycle after Start. Done=1 one cycle after the 4th accept, LoadCount=1, InstOut at address 0 = 9'h12A, Loading=0.
- Three words 0x1FF, 0x000, 0x0A5 with DataValid toggled every other cycle -> only handshaked bytes are consumed. RAM[0..2] = 1FF, 000, 0A5; LoadCount=3.
- N=1023 with data = address[8:0] -> LoadCount=1024, Done=1, RAM[1023]=9'h1FF, RAM[0] not overwritten.
- Reset asserted after 2 of 5 words -> next edge state IDLE, Done=0, LoadCount=0. RAM[0..1] keep the new values, RAM[2] unchanged. A Start asserted in the same cycle as Reset is ignored.
- Start pulsed mid-load and again in DONE -> the mid-load Start has no effect. The DONE Start clears Done/LoadCount and reloads a second program, overwriting from address 0.
- With INST_LOADER_CHECKSUM_EN defined, stream 00 00 2A 01 + trailer 2B -> Error=0. The same stream with trailer 00 -> Error=1, Done=1.
